peak_current_hb_ctrl: RTL

//  Parametrised peak-current-mode half-bridge gate controller; successor to the 8-bit fixed controller.

---
 rtl/peak_current_hb_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/peak_current_hb_ctrl.sv
// rtl/peak_current_hb_ctrl.sv - peak-current-mode half-bridge gate controller
// Free-running period counter, dead-time sequencer, blanked peak/max-on trip and latched fault shutdown.
module peak_current_hb_ctrl #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_DT      = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             cmp_i,
    input  logic             fault_i,
    input  logic             fault_clr_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] dt_i,
    input  logic [CNT_W-1:0] blank_i,
    input  logic [CNT_W-1:0] max_on_i,
    output logic             high_o,
    output logic             low_o,
    output logic             cycle_start_o,
    output logic             peak_trip_o,
    output logic             maxon_trip_o,
    output logic             fault_lat_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DT1,
        S_HS_ON,
        S_DT2,
        S_LS_ON
    } state_e;

    localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ALL_C    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_DT_C = CNT_W'(MIN_DT);

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, dt_q, blank_q, max_on_q;
    logic [CNT_W-1:0] st_cnt_q, st_cnt_d;
    logic             fault_lat_q, fault_lat_d;

    logic [SYNC_STAGES-1:0] cmp_sync_q;
    logic [SYNC_STAGES-1:0] fault_sync_q;
    logic                   cmp_s;
    logic                   fault_s;

    logic             wrap;
    logic             kill;
    logic             restart;
    logic [CNT_W-1:0] dt_eff;
    logic [CNT_W-1:0] max_on_eff;
    logic [CNT_W:0]   st_cnt_inc;
    logic             dt_done;
    logic             peak_hit;
    logic             maxon_hit;
    logic             peak_trip;
    logic             maxon_trip;

    assign cmp_s   = cmp_sync_q[SYNC_STAGES-1];
    assign fault_s = fault_sync_q[SYNC_STAGES-1];

    assign wrap  = (cnt_q == period_q);
    assign cnt_d = wrap ? '0 : cnt_q + ONE_C;

    assign dt_eff     = (dt_q < MIN_DT_C) ? MIN_DT_C : dt_q;
    assign max_on_eff = (max_on_q == '0) ? ONE_C : max_on_q;

    // One extra bit so the "+1" comparisons stay correct when st_cnt_q is saturated.
    assign st_cnt_inc = {1'b0, st_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign dt_done    = (st_cnt_inc >= {1'b0, dt_eff});
    assign peak_hit   = cmp_s && (st_cnt_q >= blank_q);
    assign maxon_hit  = (st_cnt_inc >= {1'b0, max_on_eff});

    // fault_s is included so shutdown lands on the same edge that sets the latch.
    assign kill    = !en_i || fault_lat_q || fault_s;
    assign restart = wrap && !kill;

    always_comb begin
        state_d    = state_q;
        st_cnt_d   = (st_cnt_q == ALL_C) ? st_cnt_q : st_cnt_q + ONE_C;
        peak_trip  = 1'b0;
        maxon_trip = 1'b0;
        if (kill) begin
            state_d = S_IDLE;
        end else if (restart) begin
            state_d = S_DT1;
        end else begin
            case (state_q)
                S_DT1: begin
                    if (dt_done) begin
                        state_d = S_HS_ON;
                    end
                end
                S_HS_ON: begin
                    if (peak_hit) begin
                        state_d   = S_DT2;
                        peak_trip = 1'b1;
                    end else if (maxon_hit) begin
                        state_d    = S_DT2;
                        maxon_trip = 1'b1;
                    end
                end
                S_DT2: begin
                    if (dt_done) begin
                        state_d = S_LS_ON;
                    end
                end
                S_LS_ON: state_d = S_LS_ON;
                default: state_d = S_IDLE;
            endcase
        end
        // A wrap re-entering DT1 from DT1 must still restart the dead-time count.
        if ((state_d != state_q) || restart) begin
            st_cnt_d = '0;
        end
    end

    always_comb begin
        fault_lat_d = fault_lat_q;
        if (fault_s) begin
            fault_lat_d = 1'b1;
        end else if (fault_clr_i) begin
            fault_lat_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            period_q     <= '0;
            dt_q         <= '0;
            blank_q      <= '0;
            max_on_q     <= '0;
            state_q      <= S_IDLE;
            st_cnt_q     <= '0;
            fault_lat_q  <= 1'b0;
            cmp_sync_q   <= '0;
            fault_sync_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            st_cnt_q     <= st_cnt_d;
            fault_lat_q  <= fault_lat_d;
            cmp_sync_q   <= {cmp_sync_q[SYNC_STAGES-2:0], cmp_i};
            fault_sync_q <= {fault_sync_q[SYNC_STAGES-2:0], fault_i};
            if (wrap) begin
                period_q <= period_i;
                dt_q     <= dt_i;
                blank_q  <= blank_i;
                max_on_q <= max_on_i;
            end
        end
    end

    assign high_o        = (state_q == S_HS_ON);
    assign low_o         = (state_q == S_LS_ON);
    assign cycle_start_o = (cnt_q == '0) && (state_q == S_DT1);
    assign peak_trip_o   = peak_trip;
    assign maxon_trip_o  = maxon_trip;
    assign fault_lat_o   = fault_lat_q;

endmodule
